// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-PC sequencer: state encoding, default
// vectors and the redirect-source tag used for debug visibility.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_4180;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_BR   = 2'd1,
        SRC_JR   = 2'd2,
        SRC_J    = 2'd3
    } redir_src_e;

endpackage

// File: rtl/pc_sequencer_jtarget_cat.sv
// J/JAL target formation: upper PC nibble, instruction index, word alignment.
module pc_sequencer_jtarget_cat (
    input  logic [3:0]  pc_hi_i,
    input  logic [25:0] index_i,
    output logic [31:0] target_o
);

    assign target_o = {pc_hi_i, index_i, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-PC owner for the 5-stage pipeline. Picks the next PC from PC+4,
// J/JAL, JR and EX branch sources, honours the imem ready handshake and
// parks redirects that arrive while a fetch is still outstanding.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        j_valid,
    input  logic [3:0]  j_pc_hi,
    input  logic [25:0] j_index,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] pc,
    output logic        fetch_req,
    output logic        flush_if,
    output logic        flush_id,
    output logic        misalign,
    output logic [31:0] fetch_cnt
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    logic [31:0] j_target;
    logic        jr_misaligned;
    redir_src_e  redir_src;
    logic [31:0] redir_target;
    logic        fetch_done;

    pc_sequencer_jtarget_cat u_jtarget_cat (
        .pc_hi_i  (j_pc_hi),
        .index_i  (j_index),
        .target_o (j_target)
    );

    assign jr_misaligned = (jr_target[1:0] != 2'b00);

    // Redirect candidate selection in priority order: branch, JR, J.
    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        redir_src    = SRC_NONE;
        redir_target = '0;
        if (br_taken) begin
            redir_src    = SRC_BR;
            redir_target = br_target;
        end else if (jr_valid) begin
            redir_src    = SRC_JR;
            redir_target = jr_misaligned ? EXC_VECTOR : jr_target;
        end else if (j_valid) begin
            redir_src    = SRC_J;
            redir_target = j_target;
        end
    end

    // Next-state, next-PC and per-cycle control outputs.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        fetch_req    = 1'b0;
        flush_if     = 1'b0;
        flush_id     = 1'b0;
        misalign     = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                // Redirect inputs are meaningless before the first fetch.
                state_d = ST_RUN;
            end

            ST_RUN: begin
                fetch_req = 1'b1;
                flush_id  = br_taken;
                misalign  = (redir_src == SRC_JR) && jr_misaligned;
                if (imem_ready) begin
                    if (redir_src != SRC_NONE) begin
                        // Redirect beats stall; the fetched word is wrong-path.
                        pc_d     = redir_target;
                        flush_if = 1'b1;
                    end else if (!stall) begin
                        pc_d = pc_q + PC_STEP;
                    end
                end else if (redir_src != SRC_NONE) begin
                    // Fetch still in flight: park the target until it lands.
                    pend_pc_d    = redir_target;
                    pend_valid_d = 1'b1;
                    state_d      = ST_PEND;
                end
            end

            ST_PEND: begin
                fetch_req = 1'b1;
                flush_id  = br_taken;
                if (imem_ready) begin
                    // An older-instruction branch resolving now outranks the parked target.
                    if (br_taken) begin
                        pc_d = br_target;
                    end else if (pend_valid_q) begin
                        pc_d = pend_pc_q;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                    flush_if     = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = ST_RUN;
                end else if (br_taken) begin
                    // J/JR seen here sit behind the parked redirect and are dropped.
                    pend_pc_d = br_target;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase

        fetch_done  = fetch_req && imem_ready;
        fetch_cnt_d = (fetch_done && !flush_if) ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
    end

    // Sequencer registers with asynchronous reset.
    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            fetch_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign pc        = pc_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: each stimulus cycle pushes its
// hand-computed expected outputs; a monitor pops and compares mid-cycle.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        imem_ready = 1'b0;
    logic        j_valid = 1'b0;
    logic [3:0]  j_pc_hi = '0;
    logic [25:0] j_index = '0;
    logic        jr_valid = 1'b0;
    logic [31:0] jr_target = '0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic [31:0] pc;
    logic        fetch_req;
    logic        flush_if;
    logic        flush_id;
    logic        misalign;
    logic [31:0] fetch_cnt;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        req;
        logic        fif;
        logic        fid;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   vec_id = 0;

    pc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .imem_ready (imem_ready),
        .j_valid    (j_valid),
        .j_pc_hi    (j_pc_hi),
        .j_index    (j_index),
        .jr_valid   (jr_valid),
        .jr_target  (jr_target),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .pc         (pc),
        .fetch_req  (fetch_req),
        .flush_if   (flush_if),
        .flush_id   (flush_id),
        .misalign   (misalign),
        .fetch_cnt  (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s vec%0d: got 0x%08h, expected 0x%08h", name, id, act, req);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected for the rest of that cycle.
    task automatic step(input logic r, input logic rdy, input logic stl,
                        input logic jv, input logic [3:0] jhi, input logic [25:0] jidx,
                        input logic jrv, input logic [31:0] jrt,
                        input logic brt, input logic [31:0] brtg,
                        input logic [31:0] e_pc, input logic e_req, input logic e_fif,
                        input logic e_fid, input logic e_mis, input logic [31:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst        = r;
        imem_ready = rdy;
        stall      = stl;
        j_valid    = jv;
        j_pc_hi    = jhi;
        j_index    = jidx;
        jr_valid   = jrv;
        jr_target  = jrt;
        br_taken   = brt;
        br_target  = brtg;
        vec_id++;
        e.id = vec_id; e.pc = e_pc; e.req = e_req; e.fif = e_fif;
        e.fid = e_fid; e.mis = e_mis; e.cnt = e_cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: compare queued expectations against the DUT on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc",        e.id, pc,                e.pc);
                check("fetch_req", e.id, {31'd0, fetch_req}, {31'd0, e.req});
                check("flush_if",  e.id, {31'd0, flush_if},  {31'd0, e.fif});
                check("flush_id",  e.id, {31'd0, flush_id},  {31'd0, e.fid});
                check("misalign",  e.id, {31'd0, misalign},  {31'd0, e.mis});
                check("fetch_cnt", e.id, fetch_cnt,          e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //    rst rdy stl jv hi    idx        jrv jrt           brt brtg          pc            req fif fid mis cnt
        step(1, 0, 0, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'h0000_3000, 0, 0, 0, 0, 32'd0);  // in reset
        step(0, 1, 0, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'h0000_3000, 0, 0, 0, 0, 32'd0);  // BOOT
        step(0, 1, 0, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'h0000_3000, 1, 0, 0, 0, 32'd0);
        step(0, 1, 0, 1, 4'h0, 26'hC40,   0, 32'h0,       0, 32'h0,       32'h0000_3004, 1, 1, 0, 0, 32'd1);  // J -> 0x3100
        step(0, 1, 0, 1, 4'h0, 26'hC40,   0, 32'h0,       1, 32'h3200,    32'h0000_3100, 1, 1, 1, 0, 32'd1);  // BR beats J
        step(0, 1, 0, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'h0000_3200, 1, 0, 0, 0, 32'd1);
        step(0, 0, 0, 1, 4'h0, 26'hC40,   0, 32'h0,       0, 32'h0,       32'h0000_3204, 1, 0, 0, 0, 32'd2);  // park J
        step(0, 0, 0, 0, 4'h0, 26'h0,     0, 32'h0,       1, 32'h3400,    32'h0000_3204, 1, 0, 1, 0, 32'd2);  // BR overwrites
        step(0, 0, 0, 1, 4'h0, 26'hD40,   0, 32'h0,       0, 32'h0,       32'h0000_3204, 1, 0, 0, 0, 32'd2);  // J ignored in PEND
        step(0, 1, 0, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'h0000_3204, 1, 1, 0, 0, 32'd2);  // complete
        step(0, 1, 0, 0, 4'h0, 26'h0,     1, 32'h3002,    0, 32'h0,       32'h0000_3400, 1, 1, 0, 1, 32'd2);  // misaligned JR
        step(0, 1, 0, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'h0000_4180, 1, 0, 0, 0, 32'd2);
        step(0, 1, 0, 0, 4'h0, 26'h0,     1, 32'h3000,    0, 32'h0,       32'h0000_4184, 1, 1, 0, 0, 32'd3);  // aligned JR
        step(0, 1, 0, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'h0000_3000, 1, 0, 0, 0, 32'd3);
        step(0, 1, 0, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'h0000_3004, 1, 0, 0, 0, 32'd4);
        step(0, 1, 1, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'h0000_3008, 1, 0, 0, 0, 32'd5);  // stall
        step(0, 1, 1, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'h0000_3008, 1, 0, 0, 0, 32'd6);
        step(0, 1, 1, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'h0000_3008, 1, 0, 0, 0, 32'd7);
        step(0, 1, 1, 0, 4'h0, 26'h0,     0, 32'h0,       1, 32'h5000,    32'h0000_3008, 1, 1, 1, 0, 32'd8);  // BR over stall
        step(0, 0, 0, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'h0000_5000, 1, 0, 0, 0, 32'd8);
        step(0, 1, 0, 0, 4'h0, 26'h0,     0, 32'h0,       1, 32'hFFFF_FFFC, 32'h0000_5000, 1, 1, 1, 0, 32'd8);
        step(0, 1, 0, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'hFFFF_FFFC, 1, 0, 0, 0, 32'd8);  // wrap
        step(0, 1, 0, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'h0000_0000, 1, 0, 0, 0, 32'd9);
        step(0, 0, 0, 0, 4'h0, 26'h0,     1, 32'h6000,    0, 32'h0,       32'h0000_0004, 1, 0, 0, 0, 32'd10); // park JR
        step(0, 1, 0, 0, 4'h0, 26'h0,     0, 32'h0,       1, 32'h7000,    32'h0000_0004, 1, 1, 1, 0, 32'd10); // BR wins at completion
        step(0, 0, 0, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'h0000_7000, 1, 0, 0, 0, 32'd10);
        step(0, 1, 0, 1, 4'hA, 26'h40,    0, 32'h0,       0, 32'h0,       32'h0000_7000, 1, 1, 0, 0, 32'd10); // J with pc_hi
        step(0, 0, 0, 1, 4'h0, 26'hD40,   0, 32'h0,       0, 32'h0,       32'hA000_0100, 1, 0, 0, 0, 32'd10); // park J
        step(1, 0, 0, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'h0000_3000, 0, 0, 0, 0, 32'd0);  // reset mid-PEND
        step(0, 1, 0, 0, 4'h0, 26'h0,     1, 32'h3002,    1, 32'h3300,    32'h0000_3000, 0, 0, 0, 0, 32'd0);  // BOOT ignores redirects
        step(0, 1, 0, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'h0000_3000, 1, 0, 0, 0, 32'd0);
        step(0, 1, 0, 0, 4'h0, 26'h0,     0, 32'h0,       0, 32'h0,       32'h0000_3004, 1, 0, 0, 0, 32'd1);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch PC of the static 5-stage MIPS pipeline.
- Selects the next PC from these sources: sequential PC+4, J/JAL target from ID, JR target from ID, and taken branch from EX.
- Handles the instruction-memory ready handshake and holds redirects that arrive while a fetch is outstanding.
- Generates IF/ID flush pulses and a completed-fetch counter.

Parameters:
- RESET_VECTOR, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, redirect target used when a JR target is misaligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit freeze of IF/ID.
- imem_ready  in  1  instruction memory returns data this cycle.
- j_valid  in  1  J/JAL decoded in ID.
- j_pc_hi  in  4  bits [31:28] of ID-stage PC+4.
- j_index  in  26  instr_index field of ID instruction.
- jr_valid  in  1  JR/JALR decoded in ID.
- jr_target  in  32  register operand for JR.
- br_taken  in  1  EX-stage branch resolved taken.
- br_target  in  32  EX-stage branch target.
- pc  out  32  current fetch address.
- fetch_req  out  1  fetch request to instruction memory.
- flush_if  out  1  discard the instruction completing fetch this cycle.
- flush_id  out  1  discard the ID-stage instruction.
- misalign  out  1  one-cycle pulse: JR target low bits nonzero.
- fetch_cnt  out  32  count of completed, non-flushed fetches.

Behaviour:
- Reset (async, rst=1): pc=RESET_VECTOR, state=BOOT, pend_valid=0, pend_pc=0, fetch_req=0, flush_if=0, flush_id=0, misalign=0, fetch_cnt=0.
- States:
  - BOOT: one cycle, fetch_req=0, then go to RUN.
  - RUN: no pending redirect.
  - PEND: a redirect has been captured during an outstanding fetch.
  - fetch_req=1 in RUN and PEND.
- Redirect candidate (combinational), in priority order:
  - br_taken → br_target.
  - else jr_valid → jr_target, or EXC_VECTOR if jr_target[1:0]≠0 (misalign=1 that cycle).
  - else j_valid → {j_pc_hi, j_index, 2'b00}.
- Redirect inputs are ignored in BOOT.
- Fetch completes in a cycle with fetch_req && imem_ready.
- In RUN with a completing fetch:
  - redirect present → pc<=target, flush_if=1.
  - else stall → pc holds.
  - else pc<=pc+4.
- In RUN with imem_ready=0 and a redirect present → pend_pc<=target, pend_valid<=1, go to PEND; pc holds.
- In PEND:
  - imem_ready=0:
    - br_taken overwrites pend_pc.
    - j_valid/jr_valid do not overwrite (they are on the wrong path).
  - Completing fetch: pc<=pend_pc, flush_if=1, pend_valid<=0, go to RUN.
    - A br_taken in that same cycle wins instead: pc<=br_target.
- flush_id = br_taken in any state except BOOT, combinational, independent of imem_ready and stall.
- A redirect overrides stall; stall never blocks flush.
- PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC with +4 wraps to 0.
- fetch_cnt increments on a completing fetch with flush_if=0, and wraps modulo 2^32.
- Latency: a redirect seen in cycle N gives the new pc at cycle N+1 if the fetch completes in N; otherwise pc changes in the cycle after the fetch completes.
- rst asserted mid-PEND discards the pending redirect.

Decomposition:
- Shared package holds:
  - state encoding constants (BOOT/RUN/PEND);
  - RESET_VECTOR and EXC_VECTOR defaults;
  - a redirect-source encoding (NONE/BR/JR/J) for debug.
- One natural sub-module: jtarget_cat, a combinational {pc_hi, index, 2'b00} concatenation producing the 32-bit J target.

Test Plan:
- Reset, then imem_ready=1 held for 4 cycles → pc sequence 0x3000 (BOOT), 0x3000, 0x3004, 0x3008; fetch_cnt=2 after cycle 3.
- At pc=0x3004: j_valid=1, j_pc_hi=4'h0, j_index=26'h0000C40 → flush_if=1, flush_id=0; next pc=0x0000_3100.
- br_taken=1 (br_target=0x3200) and j_valid=1 in the same cycle → flush_if=1, flush_id=1, next pc=0x3200.
- imem_ready=0 with j_valid (target 0x3100), then br_taken (0x3400) next cycle, then imem_ready=1 → state PEND; pc holds; on completion pc=0x3400, flush_if=1; fetch_cnt unchanged.
- jr_valid=1, jr_target=0x3002 → misalign=1 for one cycle; next pc=0x4180.
- stall=1 for 3 cycles at pc=0x3008 → pc holds 0x3008 and fetch_cnt still counts completed fetches; rst pulse during PEND → pc=0x3000, pend cleared, outputs at reset values.
